// File: rtl/vga_fb_wr_sched_if.sv
// Bundle of the frame-buffer write scheduler signals: timing/config inputs,
// two pixel-write requesters and the single buffer write port.
interface vga_fb_wr_sched_if #(
    parameter int X_W     = 11,
    parameter int Y_W     = 11,
    parameter int COLOR_W = 2
);
    logic [X_W-1:0]     h_active;
    logic [Y_W-1:0]     v_active;
    logic               pixel_enable;
    logic               blank_only;
    logic               clear_req;
    logic [COLOR_W-1:0] clear_color;

    logic               req0_valid;
    logic               req0_ready;
    logic [X_W-1:0]     req0_x;
    logic [Y_W-1:0]     req0_y;
    logic [COLOR_W-1:0] req0_color;

    logic               req1_valid;
    logic               req1_ready;
    logic [X_W-1:0]     req1_x;
    logic [Y_W-1:0]     req1_y;
    logic [COLOR_W-1:0] req1_color;

    logic               we;
    logic [X_W-1:0]     addr_x;
    logic [Y_W-1:0]     addr_y;
    logic [COLOR_W-1:0] color;
    logic               busy;
    logic               clear_done;
    logic               drop;

    modport master (
        output h_active, v_active, pixel_enable, blank_only, clear_req, clear_color,
        output req0_valid, req0_x, req0_y, req0_color,
        output req1_valid, req1_x, req1_y, req1_color,
        input  req0_ready, req1_ready,
        input  we, addr_x, addr_y, color, busy, clear_done, drop
    );

    modport slave (
        input  h_active, v_active, pixel_enable, blank_only, clear_req, clear_color,
        input  req0_valid, req0_x, req0_y, req0_color,
        input  req1_valid, req1_x, req1_y, req1_color,
        output req0_ready, req1_ready,
        output we, addr_x, addr_y, color, busy, clear_done, drop
    );
endinterface

// File: rtl/vga_fb_wr_sched.sv
// Frame-buffer write-port scheduler: round-robin arbitration of two pixel
// requesters with optional blanking-only gating, plus a clear-screen sweep.
module vga_fb_wr_sched #(
    parameter int X_W     = 11,
    parameter int Y_W     = 11,
    parameter int COLOR_W = 2
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    vga_fb_wr_sched_if.slave bus
);
    // state | meaning
    // IDLE  | arbitrate requesters, accept clear request
    // CLEAR | one fill write per cycle over the latched active area
    // DONE  | final fill write visible, clear_done pulse, back to IDLE
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t             state;
    logic [X_W-1:0]     clr_w, cnt_x, addr_x;
    logic [Y_W-1:0]     clr_h, cnt_y, addr_y;
    logic [COLOR_W-1:0] clr_color, color;
    logic               prefer1, we, busy, clear_done, drop;

    logic               gate_open, elig0, elig1, rdy0, rdy1, take, in_bounds;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COLOR_W-1:0] sel_color;

    always_comb begin
        gate_open = !bus.blank_only || !bus.pixel_enable;
        elig0     = (state == IDLE) && !bus.clear_req && bus.req0_valid && gate_open;
        elig1     = (state == IDLE) && !bus.clear_req && bus.req1_valid && gate_open;
        // On contention the port not served last wins.
        rdy0      = elig0 && (!elig1 || !prefer1);
        rdy1      = elig1 && (!elig0 || prefer1);
        take      = rdy0 || rdy1;
        sel_x     = rdy1 ? bus.req1_x : bus.req0_x;
        sel_y     = rdy1 ? bus.req1_y : bus.req0_y;
        sel_color = rdy1 ? bus.req1_color : bus.req0_color;
        in_bounds = (sel_x < bus.h_active) && (sel_y < bus.v_active);
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.we         = we;
    assign bus.addr_x     = addr_x;
    assign bus.addr_y     = addr_y;
    assign bus.color      = color;
    assign bus.busy       = busy;
    assign bus.clear_done = clear_done;
    assign bus.drop       = drop;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            clr_w      <= '0;
            clr_h      <= '0;
            clr_color  <= '0;
            cnt_x      <= '0;
            cnt_y      <= '0;
            prefer1    <= 1'b0;
            we         <= 1'b0;
            addr_x     <= '0;
            addr_y     <= '0;
            color      <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            drop       <= 1'b0;
        end else begin
            we         <= 1'b0;
            drop       <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear_req) begin
                        clr_w     <= bus.h_active;
                        clr_h     <= bus.v_active;
                        clr_color <= bus.clear_color;
                        cnt_x     <= '0;
                        cnt_y     <= '0;
                        busy      <= 1'b1;
                        if ((bus.h_active == '0) || (bus.v_active == '0)) begin
                            state      <= DONE;
                            clear_done <= 1'b1;
                        end else begin
                            state <= CLEAR;
                        end
                    end else if (take) begin
                        prefer1 <= rdy0;
                        if (in_bounds) begin
                            we     <= 1'b1;
                            addr_x <= sel_x;
                            addr_y <= sel_y;
                            color  <= sel_color;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    we     <= 1'b1;
                    addr_x <= cnt_x;
                    addr_y <= cnt_y;
                    color  <= clr_color;
                    if (cnt_x == clr_w - 1'b1) begin
                        cnt_x <= '0;
                        if (cnt_y == clr_h - 1'b1) begin
                            state      <= DONE;
                            clear_done <= 1'b1;
                        end else begin
                            cnt_y <= cnt_y + 1'b1;
                        end
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vga_fb_wr_sched.md
Name: vga_fb_wr_sched

Overview:
- Write-port scheduler for the 2-bit-per-pixel video frame buffer.
- Arbitrates two pixel-write requesters (port 0: host, port 1: draw engine) with valid/ready handshakes.
- Runs a built-in clear-screen sequencer that fills the active area with one colour.
- Drives the buffer's single write port (we/x/y/color), optionally restricting requester writes to blanking intervals to prevent tearing.

Parameters:
- X_W, 11, width of x coordinate
- Y_W, 11, width of y coordinate
- COLOR_W, 2, pixel colour code width

Ports:
- clk_i  in  1  system/pixel clock
- arstn_i  in  1  reset; asynchronous, active-low
- h_active_i  in  X_W  active width of current resolution (timing hd)
- v_active_i  in  Y_W  active height of current resolution (timing vd)
- pixel_enable_i  in  1  high during visible pixels (from timing generator)
- blank_only_i  in  1  1 = requester writes only when pixel_enable_i=0
- clear_req_i  in  1  single-cycle clear request
- clear_color_i  in  COLOR_W  fill colour, sampled with clear_req_i
- req0_valid_i / req1_valid_i  in  1  write request
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle
- req0_x_i / req1_x_i  in  X_W  pixel x
- req0_y_i / req1_y_i  in  Y_W  pixel y
- req0_color_i / req1_color_i  in  COLOR_W  pixel colour
- we_o  out  1  frame buffer write enable
- addr_x_o  out  X_W  write x
- addr_y_o  out  Y_W  write y
- color_o  out  COLOR_W  write colour
- busy_o  out  1  clear sequence in progress
- clear_done_o  out  1  one-cycle pulse at end of clear
- drop_o  out  1  one-cycle pulse: accepted request was out of bounds, not written

Behaviour:
- Reset:
  - FSM = IDLE.
  - All outputs 0: we_o, addr_x_o, addr_y_o, color_o, busy_o, clear_done_o, drop_o.
  - Round-robin pointer set so port 0 wins first.
  - Reset mid-clear abandons the clear; no clear_done_o pulse.
- FSM states IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clear_req_i=1. Latch h_active_i, v_active_i and clear_color_i; x/y counters <= 0.
  - If either latched dimension is 0, go to DONE instead and perform no writes.
  - CLEAR -> DONE after the step at x=h-1, y=v-1.
  - DONE -> IDLE unconditionally, one cycle.
- CLEAR sweep:
  - One write per cycle, x inner (0..h-1), y outer (0..v-1).
  - Ignores blank_only_i and pixel_enable_i.
  - Both readies held 0.
  - clear_req_i ignored while in CLEAR or DONE.
- busy_o is registered: high in CLEAR and DONE.
- clear_done_o is high in DONE. This is the cycle in which we_o for the final clear pixel is high.
- Requester arbitration applies only in IDLE, with clear_req_i=0 (clear has priority in the same cycle).
  - A port is eligible when its valid is high and the gate is open. Gate open = blank_only_i=0 or pixel_enable_i=0.
  - Exactly one eligible port: it gets ready.
  - Both eligible: the port not served last gets ready. The pointer updates only on a transfer.
- ready outputs are combinational from state, valids, gate and pointer.
  - Transfer occurs on valid&ready.
  - A requester holds valid, x, y and color stable until ready.
  - valid never depends on ready.
- Write latency is one cycle. The accepted request or clear step is registered onto addr/color; we_o is high the next cycle.
- Bounds: an accepted request with x >= h_active_i or y >= v_active_i is consumed but not written.
  - The next cycle has we_o=0 and drop_o=1.
  - addr_x_o, addr_y_o and color_o hold their previous values whenever we_o=0.
- At most one write per cycle; throughput is 1 write/cycle.
- h_active_i/v_active_i changing during CLEAR does not affect the sweep (latched values are used).

Test Plan:
- Reset check: assert arstn_i=0 mid-operation -> all outputs 0 immediately. After release, req0_valid=1 (x=5, y=7, color=2) -> req0_ready=1 same cycle; next cycle we_o=1, addr=(5,7), color_o=2.
- Round-robin: h=800, v=600, both valids held high with distinct coordinates for 6 cycles -> readies alternate 0,1,0,1,0,1. Writes appear one cycle later in that order.
- Blank gating: blank_only_i=1, req1_valid=1, pixel_enable_i=1 for 10 cycles then 0 -> req1_ready stays 0 for those 10 cycles, then asserts on the first cycle with pixel_enable_i=0.
- Clear, 4x2 active area:
  - clear_req_i with color=3 -> busy_o high from the next cycle.
  - 8 writes (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), all color 3.
  - clear_done_o coincides with the (3,1) write.
  - Readies are 0 throughout; a clear_req_i mid-sweep is ignored.
- Out of bounds: h=800, v=600, req0 at (800,10) -> accepted; next cycle we_o=0, drop_o=1. A following request at (799,599) -> written.
- Degenerate clear: h_active_i=0 -> busy_o and clear_done_o for one cycle each, no we_o. Also: reset asserted during clear at step 100 of 1280x1024 -> returns to IDLE with no clear_done_o.
